// File: rtl/k_fifo_wr_arb_t1.sv
// Round-robin write-port arbiter for the gray-pointer FIFO; drives the pointer's inc strobe.
// Optional packet lock (grant held until last or MAX_BURST beats) is enabled by FIFO_PKT_LOCK_EN.
module k_fifo_wr_arb_t1 #(
    parameter int NREQ      = 4,
    parameter int data_size = 8,
    parameter int MAX_BURST = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NREQ-1:0]             req,
    input  logic [NREQ-1:0]             last,
    input  logic [NREQ*data_size-1:0]   din,
    input  logic                        full,
    output logic                        inc,
    output logic [data_size-1:0]        wdata,
    output logic [NREQ-1:0]             gnt,
    output logic                        busy,
    output logic                        overrun
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [data_size-1:0] din_arr [NREQ];
    logic [IW-1:0]        rr_reg;
    logic [IW-1:0]        rr_next;
    logic [IW-1:0]        rr_idx;
    logic                 rr_hit;
    logic [IW-1:0]        gnt_idx;
    logic                 gnt_any;
    int                   probe;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
            assign din_arr[gi] = din[gi*data_size +: data_size];
        end
    endgenerate

    // First asserted request at or above rr, wrapping modulo NREQ.
    always_comb begin
        rr_idx = '0;
        rr_hit = 1'b0;
        probe  = 0;
        for (int k = 0; k < NREQ; k++) begin
            probe = (int'(rr_reg) + k) % NREQ;
            if (!rr_hit && req[probe]) begin
                rr_hit = 1'b1;
                rr_idx = IW'(probe);
            end
        end
    end

    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] w);
        return (w == IW'(NREQ - 1)) ? '0 : w + 1'b1;
    endfunction

`ifdef FIFO_PKT_LOCK_EN
    localparam int BW = $clog2(MAX_BURST) + 1;

    typedef enum logic {IDLE, LOCK} state_t;

    state_t         state_reg, state_next;
    logic [IW-1:0]  owner_reg, owner_next;
    logic [BW-1:0]  bcnt_reg, bcnt_next;
    logic           overrun_reg, overrun_next;

    assign gnt_idx = (state_reg == LOCK) ? owner_reg : rr_idx;
    assign gnt_any = (state_reg == LOCK) | rr_hit;
    assign busy    = (state_reg == LOCK);
    assign overrun = overrun_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            rr_reg      <= '0;
            owner_reg   <= '0;
            bcnt_reg    <= '0;
            overrun_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            rr_reg      <= rr_next;
            owner_reg   <= owner_next;
            bcnt_reg    <= bcnt_next;
            overrun_reg <= overrun_next;
        end
    end

    // Every register holds unless a beat moves; overrun is a one-cycle pulse.
    always_comb begin
        state_next   = state_reg;
        rr_next      = rr_reg;
        owner_next   = owner_reg;
        bcnt_next    = bcnt_reg;
        overrun_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (inc) begin
                    if (last[gnt_idx]) begin
                        rr_next = wrap_inc(gnt_idx);
                    end else begin
                        state_next = LOCK;
                        owner_next = gnt_idx;
                        bcnt_next  = BW'(1);
                    end
                end
            end
            LOCK: begin
                if (inc) begin
                    if (last[owner_reg] || bcnt_reg == BW'(MAX_BURST - 1)) begin
                        state_next   = IDLE;
                        rr_next      = wrap_inc(owner_reg);
                        bcnt_next    = '0;
                        overrun_next = ~last[owner_reg];
                    end else begin
                        bcnt_next = bcnt_reg + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end
`else
    logic unused_last;

    assign unused_last = ^last;
    assign gnt_idx     = rr_idx;
    assign gnt_any     = rr_hit;
    assign busy        = 1'b0;
    assign overrun     = 1'b0;
    assign rr_next     = inc ? wrap_inc(gnt_idx) : rr_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_reg <= '0;
        end else begin
            rr_reg <= rr_next;
        end
    end
`endif

    // full comes straight from a register, so masking inc here adds no extra stage.
    assign gnt   = gnt_any ? (NREQ'(1) << gnt_idx) : '0;
    assign inc   = gnt_any & req[gnt_idx] & ~full & ~rst;
    assign wdata = gnt_any ? din_arr[gnt_idx] : '0;

endmodule

// File: tb/tb_k_fifo_wr_arb_t1.sv
// Scoreboard bench for k_fifo_wr_arb_t1: directed test-plan sequences followed by random traffic.
// Expectations come from a packet-level model; lock behaviour follows FIFO_PKT_LOCK_EN.
module tb_k_fifo_wr_arb_t1;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N-1:0]    last = '0;
    logic [N*DW-1:0] din = '0;
    logic            full = 1'b0;
    logic            inc;
    logic [DW-1:0]   wdata;
    logic [N-1:0]    gnt;
    logic            busy;
    logic            overrun;

    k_fifo_wr_arb_t1 #(.NREQ(N), .data_size(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst), .req(req), .last(last), .din(din), .full(full),
        .inc(inc), .wdata(wdata), .gnt(gnt), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]  gnt;
        logic          inc;
        logic [DW-1:0] wdata;
        logic          busy;
        logic          ovr;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] data_q[$];
    int            checks = 0;
    int            failures = 0;
    int            cyc = 0;
    int            beats_seen = 0;

    // Model: next favoured requester, current packet holder (-1 = none), beats held, pending pulse.
    int rr_m = 0;
    int holder = -1;
    int held = 0;
    bit ovr_m = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL cyc=%0d %s: got %h expected %h", cyc, nm, got, want);
        end
    endtask

    task automatic model_cycle();
        exp_t          e;
        int            w;
        logic [DW-1:0] slice;
        w = holder;
        if (w < 0) begin
            for (int k = 0; k < N; k++) begin
                if (w < 0 && req[(rr_m + k) % N]) w = (rr_m + k) % N;
            end
        end
        e.gnt   = '0;
        e.wdata = '0;
        if (w >= 0) begin
            slice   = din[w*DW +: DW];
            e.gnt[w] = 1'b1;
            e.wdata = slice;
        end
        e.inc  = !rst && w >= 0 && req[w] && !full;
        e.busy = (holder >= 0);
        e.ovr  = ovr_m;
        exp_q.push_back(e);
        if (rst) begin
            rr_m = 0; holder = -1; held = 0; ovr_m = 0;
        end else begin
            ovr_m = 0;
            if (e.inc) begin
                data_q.push_back(e.wdata);
`ifdef FIFO_PKT_LOCK_EN
                if (holder < 0) begin
                    if (last[w]) rr_m = (w + 1) % N;
                    else begin holder = w; held = 1; end
                end else begin
                    held++;
                    if (last[w] || held == MB) begin
                        ovr_m  = !last[w];
                        holder = -1;
                        held   = 0;
                        rr_m   = (w + 1) % N;
                    end
                end
`else
                rr_m = (w + 1) % N;
`endif
            end
        end
    endtask

    task automatic step(input logic r, input logic [N-1:0] rq, input logic [N-1:0] ls, input logic f);
        @(posedge clk);
        #2;
        rst  = r;
        req  = rq;
        last = ls;
        full = f;
        for (int i = 0; i < N; i++) din[i*DW +: DW] = DW'($urandom);
        model_cycle();
    endtask

    // Monitor: compares the per-cycle record, and every accepted beat against the data scoreboard.
    initial begin
        exp_t          e;
        logic [DW-1:0] d;
        forever begin
            @(negedge clk);
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("gnt", 32'(gnt), 32'(e.gnt));
                chk("inc", 32'(inc), 32'(e.inc));
                chk("wdata_mux", 32'(wdata), 32'(e.wdata));
                chk("busy", 32'(busy), 32'(e.busy));
                chk("overrun", 32'(overrun), 32'(e.ovr));
            end
            if (inc === 1'b1) begin
                checks++;
                if (data_q.size() == 0) begin
                    failures++;
                    $display("FAIL cyc=%0d beat: got unexpected beat %h expected none", cyc, wdata);
                end else begin
                    d = data_q.pop_front();
                    beats_seen++;
                    $display("beat %0d cyc=%0d gnt=%b data=%h", beats_seen, cyc, gnt, wdata);
                    if (wdata !== d) begin
                        failures++;
                        $display("FAIL cyc=%0d beat_data: got %h expected %h", cyc, wdata, d);
                    end
                end
            end
        end
    end

    initial begin
        // Reset then idle.
        step(1, 4'b0000, 4'b0000, 0);
        step(1, 4'b0000, 4'b0000, 0);
        repeat (5) step(0, 4'b0000, 4'b0000, 0);
        // All four requesting, single-beat packets: strict rotation.
        repeat (5) step(0, 4'b1111, 4'b1111, 0);
        // Held off by full, then req0 goes first and req2 follows.
        step(1, 4'b0000, 4'b0000, 0);
        repeat (3) step(0, 4'b0101, 4'b0101, 1);
        repeat (2) step(0, 4'b0101, 4'b0101, 0);
        // Point rr at req1, then a three-beat req1 packet against req0/req2.
        step(1, 4'b0000, 4'b0000, 0);
        step(0, 4'b0001, 4'b0001, 0);
        step(0, 4'b0111, 4'b0101, 0);
        step(0, 4'b0111, 4'b0101, 0);
        step(0, 4'b0111, 4'b0111, 0);
        step(0, 4'b0111, 4'b0111, 0);
        // Point rr at req3, then req3 streams without last until forced release.
        step(1, 4'b0000, 4'b0000, 0);
        step(0, 4'b0100, 4'b0100, 0);
        repeat (6) step(0, 4'b1001, 4'b0000, 0);
        // Reset during beat 2 of a req2 packet; req0 must win afterwards.
        step(1, 4'b0000, 4'b0000, 0);
        step(0, 4'b0100, 4'b0000, 0);
        step(1, 4'b0101, 4'b0000, 0);
        repeat (2) step(0, 4'b0101, 4'b0101, 0);
        // Random traffic.
        for (int n = 0; n < 800; n++) begin
            logic [N-1:0] rq;
            logic [N-1:0] ls;
            rq = N'($urandom);
            ls = '0;
            for (int i = 0; i < N; i++) ls[i] = ($urandom_range(0, 2) == 0);
            step($urandom_range(0, 99) == 0, rq, ls, $urandom_range(0, 3) == 0);
        end
        step(0, 4'b0000, 4'b0000, 0);
        step(0, 4'b0000, 4'b0000, 0);
        @(negedge clk);
        #1;
        chk("beats_left", 32'(data_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
